// File: rtl/tempo_controller.sv
// tempo_controller: front-panel BPM setpoint from debounced inc/dec buttons.
// Tap steps once, holding auto-repeats, pressing both buttons restores the
// default tempo. Output is clamped to [BPM_MIN, BPM_MAX].
// Optional feature macro: TEMPO_ACCEL_EN (accelerated repeat steps).
//
// state  | meaning
// IDLE   | no button held; a single press steps once and enters HOLD
// HOLD   | button held, waiting HOLD_CYCLES for the first auto-repeat
// REPEAT | auto-repeating every REPEAT_CYCLES
// CHORD  | both buttons were pressed; wait for both to be released
module tempo_controller #(
  parameter int BPM_MIN       = 40,
  parameter int BPM_MAX       = 240,
  parameter int BPM_DEFAULT   = 120,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int FAST_AFTER    = 8,
  parameter int FAST_STEP     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [7:0] bpm,
  output logic       bpm_changed,
  output logic       at_min,
  output logic       at_max
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  localparam logic [1:0] CHORD  = 2'd3;

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  localparam logic [8:0] MIN9 = 9'(BPM_MIN);
  localparam logic [8:0] MAX9 = 9'(BPM_MAX);
  localparam logic [8:0] DEF9 = 9'(BPM_DEFAULT);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;      // 1 = increment
  logic             do_step, load_default;
  logic [8:0]       step_size;
  logic [8:0]       bpm_ext, sum, bpm_new;
  logic             dir_btn, opp_btn;

`ifdef TEMPO_ACCEL_EN
  localparam int RPT_W = $clog2(FAST_AFTER + 2);
  localparam logic [RPT_W-1:0] FAST_N = RPT_W'(FAST_AFTER);
  logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
`endif

  assign dir_btn = dir ? btn_inc : btn_dec;
  assign opp_btn = dir ? btn_dec : btn_inc;

  // Next-state, step request and step size
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dir_nxt      = dir;
    do_step      = 1'b0;
    load_default = 1'b0;
    step_size    = 9'd1;
`ifdef TEMPO_ACCEL_EN
    rpt_nxt      = rpt_cnt;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
`ifdef TEMPO_ACCEL_EN
        rpt_nxt = '0;
`endif
        if (btn_inc && btn_dec) begin
          load_default = 1'b1;
          state_nxt    = CHORD;
        end else if (btn_inc) begin
          do_step   = 1'b1;
          dir_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (btn_dec) begin
          do_step   = 1'b1;
          dir_nxt   = 1'b0;
          state_nxt = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // The opposite button wins over release and timer expiry.
        if (opp_btn) begin
          load_default = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = CHORD;
        end else if (!dir_btn) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == ((state == HOLD) ? HOLD_TC : REPEAT_TC)) begin
          do_step   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
`ifdef TEMPO_ACCEL_EN
          if (state == HOLD) begin
            rpt_nxt = RPT_W'(1);
          end else begin
            if (rpt_cnt >= FAST_N) step_size = 9'(FAST_STEP);
            if (rpt_cnt < FAST_N) rpt_nxt = rpt_cnt + RPT_W'(1);
          end
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
        if (!btn_inc && !btn_dec) state_nxt = IDLE;
      end
    endcase
  end

  // Clamped 9-bit arithmetic for the candidate setpoint
  always_comb begin
    bpm_ext = {1'b0, bpm};
    sum     = bpm_ext + step_size;
    bpm_new = bpm_ext;
    if (load_default) begin
      bpm_new = DEF9;
    end else if (do_step) begin
      if (dir_nxt) bpm_new = (sum > MAX9) ? MAX9 : sum;
      else         bpm_new = (bpm_ext >= MIN9 + step_size) ? bpm_ext - step_size : MIN9;
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dir         <= 1'b0;
      bpm         <= DEF9[7:0];
      bpm_changed <= 1'b0;
      at_min      <= (BPM_DEFAULT == BPM_MIN);
      at_max      <= (BPM_DEFAULT == BPM_MAX);
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dir         <= dir_nxt;
      bpm         <= bpm_new[7:0];
      bpm_changed <= (bpm_new[7:0] != bpm);
      at_min      <= (bpm_new == MIN9);
      at_max      <= (bpm_new == MAX9);
    end
  end

`ifdef TEMPO_ACCEL_EN
  // Repeat-step count, saturating at FAST_AFTER
  always_ff @(posedge clk) begin
    if (reset) rpt_cnt <= '0;
    else       rpt_cnt <= rpt_nxt;
  end
`endif

endmodule
